// File: rtl/debounce_switch.sv
// Two-flop (or longer) synchroniser followed by a stable-level counter.
// Emits a clean level plus one-cycle rise/fall strobes and a pending-change flag.
module debounce_switch #(
  parameter int   DEBOUNCE_LIMIT = 250000,
  parameter int   SYNC_STAGES    = 2,
  parameter logic RESET_VALUE    = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Rise,
  output logic o_Fall,
  output logic o_Busy
);

  localparam int CW = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_LIMIT - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_out;
  logic [CW-1:0]          count;
  logic [CW-1:0]          count_next;
  logic                   change;

  assign sync_out = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], i_Switch};
    end
  end

  // Any return to the current output level restarts the stability window.
  always_comb begin
    change     = 1'b0;
    count_next = '0;
    if (sync_out != o_Switch) begin
      if (count == LAST) begin
        change = 1'b1;
      end else begin
        count_next = count + CW'(1);
      end
    end
  end

  // Busy is taken from the next count so it always matches the count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count    <= '0;
      o_Switch <= RESET_VALUE;
      o_Rise   <= 1'b0;
      o_Fall   <= 1'b0;
      o_Busy   <= 1'b0;
    end else begin
      count  <= count_next;
      o_Busy <= (count_next != '0);
      o_Rise <= change & sync_out;
      o_Fall <= change & ~sync_out;
      if (change) begin
        o_Switch <= sync_out;
      end
    end
  end

endmodule

// File: tb/tb_debounce_switch.sv
// Bench for debounce_switch: a LIMIT=4 instance and a LIMIT=1/RESET_VALUE=1 instance.
// Expected output vectors are queued per cycle and popped after each rising edge.
module tb_debounce_switch;

  logic clk = 1'b0;
  logic reset_n;
  logic sw, sw1;
  logic o_sw, o_rise, o_fall, o_busy;
  logic o1_sw, o1_rise, o1_fall, o1_busy;

  logic [7:0] sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debounce_switch #(.DEBOUNCE_LIMIT(4), .SYNC_STAGES(2), .RESET_VALUE(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .i_Switch(sw),
    .o_Switch(o_sw), .o_Rise(o_rise), .o_Fall(o_fall), .o_Busy(o_busy)
  );

  debounce_switch #(.DEBOUNCE_LIMIT(1), .SYNC_STAGES(2), .RESET_VALUE(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .i_Switch(sw1),
    .o_Switch(o1_sw), .o_Rise(o1_rise), .o_Fall(o1_fall), .o_Busy(o1_busy)
  );

  // Vector layout: {switch, rise, fall, busy} of dut, then the same for dut1.
  function automatic void push_exp(input logic [3:0] a, input logic [3:0] b);
    sb.push_back({a, b});
  endfunction

  task automatic test_reset();
    logic [7:0] exp, obs;
    reset_n = 1'b0;
    sw      = 1'b1;
    sw1     = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push_exp(4'b0000, 4'b1000);
      @(posedge clk); #1;
      exp = sb.pop_front();
      obs = {o_sw, o_rise, o_fall, o_busy, o1_sw, o1_rise, o1_fall, o1_busy};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL reset_hold cycle %0d: got %b expected %b", k, obs, exp);
      end
    end
    sw      = 1'b0;
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push_exp(4'b0000, 4'b1000);
      @(posedge clk); #1;
      exp = sb.pop_front();
      obs = {o_sw, o_rise, o_fall, o_busy, o1_sw, o1_rise, o1_fall, o1_busy};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL reset_release cycle %0d: got %b expected %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [3:0] tbl[8] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001,
                           4'b0001, 4'b1100, 4'b1000, 4'b1000};
    logic [7:0] exp, obs;
    sw = 1'b1;
    for (int k = 0; k < 8; k++) begin
      push_exp(tbl[k], 4'b1000);
      @(posedge clk); #1;
      exp = sb.pop_front();
      obs = {o_sw, o_rise, o_fall, o_busy, o1_sw, o1_rise, o1_fall, o1_busy};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL clean_press edge %0d: got %b expected %b", k + 1, obs, exp);
      end
    end
  endtask

  task automatic test_clean_release();
    logic [3:0] tbl[8] = '{4'b1000, 4'b1000, 4'b1001, 4'b1001,
                           4'b1001, 4'b0010, 4'b0000, 4'b0000};
    logic [7:0] exp, obs;
    sw = 1'b0;
    for (int k = 0; k < 8; k++) begin
      push_exp(tbl[k], 4'b1000);
      @(posedge clk); #1;
      exp = sb.pop_front();
      obs = {o_sw, o_rise, o_fall, o_busy, o1_sw, o1_rise, o1_fall, o1_busy};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL clean_release edge %0d: got %b expected %b", k + 1, obs, exp);
      end
    end
  endtask

  // High 3, low 2, high 1, low 1, then high: only the final high survives 4 counts.
  task automatic test_bounce();
    logic       pat[14] = '{1, 1, 1, 0, 0, 1, 0, 1, 1, 1, 1, 1, 1, 1};
    logic [3:0] tbl[14] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001,
                            4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001,
                            4'b0001, 4'b0001, 4'b1100, 4'b1000};
    logic [7:0] exp, obs;
    for (int k = 0; k < 14; k++) begin
      sw = pat[k];
      push_exp(tbl[k], 4'b1000);
      @(posedge clk); #1;
      exp = sb.pop_front();
      obs = {o_sw, o_rise, o_fall, o_busy, o1_sw, o1_rise, o1_fall, o1_busy};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL bounce edge %0d: got %b expected %b", k + 1, obs, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] exp, obs;
    #2 reset_n = 1'b0;
    #1;
    push_exp(4'b0000, 4'b1000);
    exp = sb.pop_front();
    obs = {o_sw, o_rise, o_fall, o_busy, o1_sw, o1_rise, o1_fall, o1_busy};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL async_reset_immediate: got %b expected %b", obs, exp);
    end
    sw = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push_exp(4'b0000, 4'b1000);
      @(posedge clk); #1;
      if (k == 0) reset_n = 1'b1;
      exp = sb.pop_front();
      obs = {o_sw, o_rise, o_fall, o_busy, o1_sw, o1_rise, o1_fall, o1_busy};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL async_reset_after cycle %0d: got %b expected %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    logic [3:0] pre[4] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001};
    logic [3:0] tbl[8] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001,
                           4'b0001, 4'b1100, 4'b1000, 4'b1000};
    logic [7:0] exp, obs;
    sw = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push_exp(pre[k], 4'b1000);
      @(posedge clk); #1;
      exp = sb.pop_front();
      obs = {o_sw, o_rise, o_fall, o_busy, o1_sw, o1_rise, o1_fall, o1_busy};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL mid_count_pre edge %0d: got %b expected %b", k + 1, obs, exp);
      end
    end
    reset_n = 1'b0;
    push_exp(4'b0000, 4'b1000);
    @(posedge clk); #1;
    exp = sb.pop_front();
    obs = {o_sw, o_rise, o_fall, o_busy, o1_sw, o1_rise, o1_fall, o1_busy};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL mid_count_in_reset: got %b expected %b", obs, exp);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      push_exp(tbl[k], 4'b1000);
      @(posedge clk); #1;
      exp = sb.pop_front();
      obs = {o_sw, o_rise, o_fall, o_busy, o1_sw, o1_rise, o1_fall, o1_busy};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL mid_count_post edge %0d: got %b expected %b", k + 1, obs, exp);
      end
    end
  endtask

  task automatic test_limit_one();
    logic [3:0] tbl[4] = '{4'b1000, 4'b1000, 4'b0010, 4'b0000};
    logic [7:0] exp, obs;
    sw1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push_exp(4'b1000, tbl[k]);
      @(posedge clk); #1;
      exp = sb.pop_front();
      obs = {o_sw, o_rise, o_fall, o_busy, o1_sw, o1_rise, o1_fall, o1_busy};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL limit_one edge %0d: got %b expected %b", k + 1, obs, exp);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    sw      = 1'b1;
    sw1     = 1'b1;
    test_reset();
    test_clean_press();
    test_clean_release();
    test_bounce();
    test_async_reset();
    test_reset_mid_count();
    test_limit_one();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/debounce_switch.md
Name: debounce_switch

Overview:
- Cleans one mechanical switch/button input for the game logic (frog movement and similar).
- Synchronises the asynchronous raw input into the clk domain.
- Propagates a level change to the output only after the synchronised input has held the new level for DEBOUNCE_LIMIT consecutive cycles.
- Also provides one-cycle rise and fall strobes, so consumers may drop their own edge detectors.

Parameters:
- DEBOUNCE_LIMIT, 250000, consecutive stable cycles required before the output changes (10 ms at 25 MHz); legal range is 1 or more.
- SYNC_STAGES, 2, number of synchroniser flops on i_Switch; legal range is 2 or more.
- RESET_VALUE, 0, level loaded into the synchroniser and into o_Switch on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- i_Switch  input  1  raw switch level; asynchronous and may bounce.
- o_Switch  output  1  debounced level.
- o_Rise  output  1  one-cycle pulse when o_Switch goes 0->1.
- o_Fall  output  1  one-cycle pulse when o_Switch goes 1->0.
- o_Busy  output  1  high while the debounce counter is non-zero, i.e. a change is pending.

Behaviour:
- **Reset** (reset_n low), asynchronous and independent of clk:
  - all synchroniser flops and o_Switch take RESET_VALUE;
  - counter is 0;
  - o_Rise, o_Fall and o_Busy are 0.
- **Reset release**: normal operation begins on the next rising edge. Asserting reset mid-count abandons any pending change.
- **Synchroniser**: shift chain of SYNC_STAGES flops; sync_out is the last stage. No logic on i_Switch before the first flop.
- **Counter**: width is clog2(DEBOUNCE_LIMIT), minimum 1 bit. On each edge:
  - sync_out == o_Switch: counter <= 0.
  - sync_out != o_Switch and counter == DEBOUNCE_LIMIT-1: o_Switch <= sync_out, counter <= 0.
  - Otherwise: counter <= counter + 1.
  - The counter can never exceed DEBOUNCE_LIMIT-1; no wrap-around.
- **Latency**: if i_Switch changes and then holds, o_Switch follows on the (SYNC_STAGES + DEBOUNCE_LIMIT)-th rising edge after the change.
  - With DEBOUNCE_LIMIT=1 the output follows on the first differing cycle, giving pure synchroniser latency.
- **Glitch rejection**: any return of sync_out to the o_Switch level before the limit is reached clears the counter.
  - A bounce train therefore restarts the full DEBOUNCE_LIMIT window from its last transition.
- **Strobes**: o_Rise and o_Fall are registered and asserted in the same cycle o_Switch takes its new value, for exactly one cycle.
  - They are never both high.
  - They do not fire on reset or on reset release.
- **o_Busy**: registered; equals (counter != 0).
- No combinational path from any input to any output.

Test Plan (DEBOUNCE_LIMIT=4, SYNC_STAGES=2, RESET_VALUE=0 unless stated):
- **Reset**: hold reset_n low with i_Switch=1 and clocks running -> o_Switch=0, o_Rise=0, o_Fall=0, o_Busy=0 throughout. Assert reset_n low between clock edges -> outputs clear immediately, without waiting for an edge.
- **Clean press**: drive i_Switch 0->1 and hold -> o_Switch goes 1 on the 6th rising edge after the change. o_Rise is high for exactly that one cycle. o_Busy is high for the 3 cycles before it.
- **Clean release**: from o_Switch=1, drive i_Switch 1->0 and hold -> o_Switch goes 0 on the 6th edge. o_Fall pulses once; o_Rise stays 0.
- **Bounce**: from o_Switch=0, drive i_Switch high 3 cycles, low 2, high 1, low 1, then high and hold -> no output change during the bounce. o_Switch rises 6 edges after the final 0->1 transition, with a single o_Rise pulse.
- **Reset mid-count**: with i_Switch high and the counter at 2, pulse reset_n low for 1 cycle -> o_Switch stays 0. After release, o_Switch rises on the 6th edge after release (the synchroniser refills, then a full count).
- **Limit of 1, RESET_VALUE=1**: re-parameterise with DEBOUNCE_LIMIT=1 and RESET_VALUE=1; after reset, drive i_Switch=0 -> o_Switch falls on the 3rd edge after the change, with one o_Fall pulse.
